// File: rtl/mips_loader_pkg.sv
// mips_loader_pkg: shared state encoding, stream widths and index sizing for mips_program_loader.
package mips_loader_pkg;
  localparam int LEN_WIDTH = 16;
  localparam int BYTES_PER_WORD = 4;
  localparam int LANE_WIDTH = $clog2(BYTES_PER_WORD);
  localparam logic [LANE_WIDTH-1:0] LANE_LAST = LANE_WIDTH'(BYTES_PER_WORD - 1);

  typedef enum logic [2:0] {IDLE, LEN_LO, LEN_HI, DATA, CHECK, DONE, ERROR} loaderState_e;

  function automatic int indexWidth(input int depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/mips_program_loader_word_assembler.sv
// word_assembler: packs four accepted bytes LSB-first into a 32-bit word, flagging the 4th byte.
module word_assembler
  import mips_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        byteValid,
  input  logic [7:0]  byteData,
  output logic        wordValid,
  output logic [31:0] word
);
  logic [LANE_WIDTH-1:0] lane;
  logic [23:0] shiftReg;

  // The completed word includes the byte arriving this cycle, so the top can latch it on the same edge.
  assign wordValid = byteValid && (lane == LANE_LAST);
  assign word = {byteData, shiftReg};

  always_ff @(posedge clk)
    if (reset || clear) begin
      lane <= '0;
      shiftReg <= '0;
    end else if (byteValid) begin
      lane <= lane + LANE_WIDTH'(1);
      shiftReg <= word[31:8];
    end
endmodule

// File: rtl/mips_program_loader.sv
// mips_program_loader: loads a length-prefixed byte image into program memory, holding the CPU in reset until done.
// Define LOADER_CHECKSUM_EN to require a trailing XOR checksum byte over the data bytes.
module mips_program_loader
  import mips_loader_pkg::*;
#(
  parameter int          MEMORY_DEPTH = 32,
  parameter logic [31:0] BASE_ADDRESS = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        mem_write_enable,
  output logic [31:0] mem_write_address,
  output logic [31:0] mem_write_data,
  output logic        cpu_reset,
  output logic        load_done,
  output logic        load_error
);
  localparam int IW = indexWidth(MEMORY_DEPTH);

  loaderState_e state;
  logic [7:0] lenLo;
  logic [IW-1:0] wordIndex, wordCount;
  logic [LEN_WIDTH-1:0] lenValue;
  logic accept, startLoad, wordValid;
  logic [31:0] wordData;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0] checksum;
`endif

  assign accept = byte_valid && byte_ready;
  assign startLoad = start && (state == IDLE || state == DONE || state == ERROR);
  assign lenValue = {byte_data, lenLo};

  word_assembler u_assembler (
    .clk       (clk),
    .reset     (reset),
    .clear     (startLoad),
    .byteValid (accept && state == DATA),
    .byteData  (byte_data),
    .wordValid (wordValid),
    .word      (wordData)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      byte_ready <= 1'b0;
      mem_write_enable <= 1'b0;
      mem_write_address <= '0;
      mem_write_data <= '0;
      cpu_reset <= 1'b1;
      load_done <= 1'b0;
      load_error <= 1'b0;
      lenLo <= '0;
      wordIndex <= '0;
      wordCount <= '0;
`ifdef LOADER_CHECKSUM_EN
      checksum <= '0;
`endif
    end else begin
      mem_write_enable <= 1'b0;
      if (startLoad) begin
        state <= LEN_LO;
        byte_ready <= 1'b1;
        cpu_reset <= 1'b1;
        load_done <= 1'b0;
        load_error <= 1'b0;
        wordIndex <= '0;
`ifdef LOADER_CHECKSUM_EN
        checksum <= '0;
`endif
      end else if (mem_write_enable) begin
        // End of a write pulse: the CPU is only released once the last word has landed.
        if (wordIndex != wordCount)
          byte_ready <= 1'b1;
        else begin
`ifdef LOADER_CHECKSUM_EN
          state <= CHECK;
          byte_ready <= 1'b1;
`else
          state <= DONE;
          cpu_reset <= 1'b0;
          load_done <= 1'b1;
`endif
        end
      end else if (accept) begin
        case (state)
          LEN_LO: begin
            lenLo <= byte_data;
            state <= LEN_HI;
          end
          LEN_HI:
            if (lenValue == '0 || int'(lenValue) > MEMORY_DEPTH) begin
              state <= ERROR;
              byte_ready <= 1'b0;
              load_error <= 1'b1;
            end else begin
              wordCount <= lenValue[IW-1:0];
              state <= DATA;
            end
          DATA: begin
`ifdef LOADER_CHECKSUM_EN
            checksum <= checksum ^ byte_data;
`endif
            if (wordValid) begin
              mem_write_enable <= 1'b1;
              mem_write_address <= BASE_ADDRESS + 32'({wordIndex, 2'b00});
              mem_write_data <= wordData;
              wordIndex <= wordIndex + IW'(1);
              byte_ready <= 1'b0;
            end
          end
`ifdef LOADER_CHECKSUM_EN
          CHECK: begin
            byte_ready <= 1'b0;
            state <= (checksum == byte_data) ? DONE : ERROR;
            cpu_reset <= checksum != byte_data;
            load_done <= checksum == byte_data;
            load_error <= checksum != byte_data;
          end
`endif
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_mips_program_loader.sv
// tb_mips_program_loader: randomized bench checking every cycle against a byte-count model of the loader.
// Honours LOADER_CHECKSUM_EN to append and verify the trailing checksum byte.
module tb_mips_program_loader;
  localparam int DEPTH = 32;
  localparam logic [31:0] BASE = 32'h0000_0000;
`ifdef LOADER_CHECKSUM_EN
  localparam bit HAS_SUM = 1'b1;
`else
  localparam bit HAS_SUM = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset, start, byte_valid;
  logic [7:0] byte_data;
  logic byte_ready, mem_write_enable, cpu_reset, load_done, load_error;
  logic [31:0] mem_write_address, mem_write_data;

  int nCompared = 0;
  int nMismatched = 0;
  int writeCount = 0;
  logic [31:0] memImg [64];
  logic [7:0] stream [$];
  logic [31:0] words [$];

  // Reference model: tracks position in the stream by byte count, not by loader state.
  bit mActive = 1'b0;
  bit mAccepted = 1'b0;
  int mCnt = 0;
  int mN = 0;
  logic [7:0] mLo = '0;
  logic [7:0] mXor = '0;
  logic [7:0] wb [4];
  logic eReady = 1'b0, eWe = 1'b0, eCpuReset = 1'b1, eDone = 1'b0, eErr = 1'b0;
  logic [31:0] eAddr = '0, eData = '0;

  mips_program_loader #(.MEMORY_DEPTH(DEPTH), .BASE_ADDRESS(BASE)) dut (
    .clk               (clk),
    .reset             (reset),
    .start             (start),
    .byte_valid        (byte_valid),
    .byte_data         (byte_data),
    .byte_ready        (byte_ready),
    .mem_write_enable  (mem_write_enable),
    .mem_write_address (mem_write_address),
    .mem_write_data    (mem_write_data),
    .cpu_reset         (cpu_reset),
    .load_done         (load_done),
    .load_error        (load_error)
  );

  always #5 clk = ~clk;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("FAIL %s: got %h, expected %h at t=%0t", name, act, exp, $time);
    end
  endfunction

  function automatic void modelFinish(input bit ok);
    mActive = 1'b0;
    eReady = 1'b0;
    eCpuReset = !ok;
    eDone = ok;
    eErr = !ok;
  endfunction

  function automatic void modelStep();
    bit wasWe;
    int d;
    wasWe = eWe;
    mAccepted = 1'b0;
    eWe = 1'b0;
    if (reset) begin
      mActive = 1'b0;
      eReady = 1'b0;
      eAddr = '0;
      eData = '0;
      eCpuReset = 1'b1;
      eDone = 1'b0;
      eErr = 1'b0;
    end else if (start && !mActive) begin
      mActive = 1'b1;
      mCnt = 0;
      mXor = '0;
      eReady = 1'b1;
      eCpuReset = 1'b1;
      eDone = 1'b0;
      eErr = 1'b0;
    end else if (wasWe) begin
      if (mCnt < 2 + 4 * mN || HAS_SUM) eReady = 1'b1;
      else modelFinish(1'b1);
    end else if (byte_valid && eReady) begin
      mAccepted = 1'b1;
      d = mCnt - 2;
      mCnt++;
      if (d == -2) mLo = byte_data;
      else if (d == -1) begin
        mN = int'({byte_data, mLo});
        if (mN == 0 || mN > DEPTH) modelFinish(1'b0);
      end else if (d < 4 * mN) begin
        mXor ^= byte_data;
        wb[d % 4] = byte_data;
        if (d % 4 == 3) begin
          eWe = 1'b1;
          eReady = 1'b0;
          eAddr = BASE + 32'(4 * (d / 4));
          eData = {wb[3], wb[2], wb[1], wb[0]};
        end
      end else modelFinish(byte_data == mXor);
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    modelStep();
    @(negedge clk);
    check("byte_ready", 32'(byte_ready), 32'(eReady));
    check("mem_write_enable", 32'(mem_write_enable), 32'(eWe));
    check("mem_write_address", mem_write_address, eAddr);
    check("mem_write_data", mem_write_data, eData);
    check("cpu_reset", 32'(cpu_reset), 32'(eCpuReset));
    check("load_done", 32'(load_done), 32'(eDone));
    check("load_error", 32'(load_error), 32'(eErr));
    if (mem_write_enable === 1'b1) begin
      memImg[mem_write_address[7:2]] = mem_write_data;
      writeCount++;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulseStart();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic clearLog();
    writeCount = 0;
    foreach (memImg[i]) memImg[i] = '0;
  endtask

  function automatic void test1Words();
    words.delete();
    words.push_back(32'h2008_0005);
    words.push_back(32'h2009_0007);
  endfunction

  function automatic void makeStream(input int n, input logic [7:0] sumFlip);
    logic [7:0] x;
    x = '0;
    stream.delete();
    stream.push_back(8'(n));
    stream.push_back(8'(n >> 8));
    foreach (words[k])
      for (int j = 0; j < 4; j++) begin
        stream.push_back(words[k][8*j +: 8]);
        x ^= words[k][8*j +: 8];
      end
    if (HAS_SUM) stream.push_back(x ^ sumFlip);
  endfunction

  // mode 0: always valid, 1: valid every other cycle, 2: random gaps
  task automatic sendRange(input int from, input int to, input int mode);
    int i;
    int budget;
    bit phase;
    bit v;
    i = from;
    budget = 0;
    phase = 1'b0;
    while (i < to) begin
      v = (mode == 0) ? 1'b1 : (mode == 1) ? phase : 1'($urandom_range(0, 1));
      phase = !phase;
      byte_valid = v;
      byte_data = v ? stream[i] : 8'($urandom);
      tick();
      if (mAccepted) i++;
      budget++;
      if (budget > 20 * (to - from) + 100) begin
        nCompared++;
        nMismatched++;
        $display("FAIL stream_timeout: got %0d of %0d bytes accepted", i - from, to - from);
        i = to;
      end
    end
    byte_valid = 1'b0;
  endtask

  task automatic checkTest1Loaded(input string tag);
    check({tag, "_word0"}, memImg[0], 32'h2008_0005);
    check({tag, "_word1"}, memImg[1], 32'h2009_0007);
    check({tag, "_writes"}, 32'(writeCount), 32'd2);
    check({tag, "_done"}, 32'(load_done), 32'd1);
    check({tag, "_cpu_reset"}, 32'(cpu_reset), 32'd0);
  endtask

  task automatic checkResetValues(input string tag);
    check({tag, "_ready"}, 32'(byte_ready), 32'd0);
    check({tag, "_we"}, 32'(mem_write_enable), 32'd0);
    check({tag, "_addr"}, mem_write_address, 32'd0);
    check({tag, "_data"}, mem_write_data, 32'd0);
    check({tag, "_cpu_reset"}, 32'(cpu_reset), 32'd1);
    check({tag, "_done"}, 32'(load_done), 32'd0);
    check({tag, "_error"}, 32'(load_error), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach its summary");
    $fatal(1);
  end

  initial begin
    int n;
    bit badLen;
    reset = 1'b1;
    start = 1'b0;
    byte_valid = 1'b0;
    byte_data = '0;
    idle(2);
    checkResetValues("reset");
    reset = 1'b0;
    idle(2);

    clearLog();
    test1Words();
    makeStream(2, 8'h00);
    pulseStart();
    check("t1_ready_after_start", 32'(byte_ready), 32'd1);
    sendRange(0, stream.size(), 0);
    idle(3);
    checkTest1Loaded("t1");

    pulseStart();
    check("restart_cpu_reset", 32'(cpu_reset), 32'd1);
    check("restart_done", 32'(load_done), 32'd0);
    check("restart_ready", 32'(byte_ready), 32'd1);

    clearLog();
    stream.delete();
    stream.push_back(8'h21);
    stream.push_back(8'h00);
    sendRange(0, 2, 0);
    check("len33_error", 32'(load_error), 32'd1);
    check("len33_cpu_reset", 32'(cpu_reset), 32'd1);
    idle(3);
    check("len33_writes", 32'(writeCount), 32'd0);

    pulseStart();
    stream.delete();
    stream.push_back(8'h00);
    stream.push_back(8'h00);
    sendRange(0, 2, 0);
    check("len0_error", 32'(load_error), 32'd1);
    idle(2);
    check("len0_writes", 32'(writeCount), 32'd0);

`ifdef LOADER_CHECKSUM_EN
    clearLog();
    test1Words();
    makeStream(2, 8'h07);
    pulseStart();
    sendRange(0, stream.size(), 0);
    idle(3);
    check("badsum_writes", 32'(writeCount), 32'd2);
    check("badsum_error", 32'(load_error), 32'd1);
    check("badsum_cpu_reset", 32'(cpu_reset), 32'd1);
    check("badsum_done", 32'(load_done), 32'd0);
`endif

    clearLog();
    test1Words();
    makeStream(2, 8'h00);
    pulseStart();
    sendRange(0, stream.size(), 1);
    idle(3);
    checkTest1Loaded("toggle");

    clearLog();
    pulseStart();
    sendRange(0, 5, 0);
    reset = 1'b1;
    tick();
    checkResetValues("midreset");
    reset = 1'b0;
    idle(2);
    check("midreset_writes", 32'(writeCount), 32'd0);
    pulseStart();
    sendRange(0, stream.size(), 2);
    idle(3);
    checkTest1Loaded("reload");

    clearLog();
    pulseStart();
    sendRange(0, 4, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_in_data_ready", 32'(byte_ready), 32'd1);
    sendRange(4, stream.size(), 0);
    idle(3);
    checkTest1Loaded("start_in_data");

    for (int t = 0; t < 25; t++) begin
      case ($urandom_range(0, 9))
        0: n = 0;
        1: n = DEPTH + 1 + int'($urandom_range(0, 300));
        2: n = DEPTH;
        default: n = int'($urandom_range(1, 6));
      endcase
      badLen = (n == 0 || n > DEPTH);
      words.delete();
      if (!badLen)
        for (int k = 0; k < n; k++) words.push_back($urandom);
      makeStream(n, ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00);
      pulseStart();
      sendRange(0, badLen ? 2 : stream.size(), int'($urandom_range(0, 2)));
      idle(int'($urandom_range(2, 5)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end
endmodule

// File: doc/mips_program_loader.md
# mips_program_loader

Upstream boot stage for the single-cycle MIPS processor. Receives a length-prefixed byte stream, assembles little-endian 32-bit words and writes them into program memory through a write port. Holds the processor in reset until the image is fully and correctly loaded, then releases it so fetch starts at PC reset value with the new program in place.

## Interface
Parameters:
- MEMORY_DEPTH, 32, program memory depth in words; the largest accepted word count.
- BASE_ADDRESS, 32'h0000_0000, byte address written for word 0.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  synchronous, active-high; one clock; reset is synchronous and active-high.
- start  input  1  one-cycle pulse that begins a load; honoured only in IDLE, DONE, ERROR.
- byte_valid  input  1  byte_data holds a valid byte.
- byte_data  input  8  stream byte.
- byte_ready  output  1  loader accepts a byte this cycle.
- mem_write_enable  output  1  one-cycle program memory write strobe.
- mem_write_address  output  32  word-aligned byte address.
- mem_write_data  output  32  assembled word.
- cpu_reset  output  1  processor reset; high except in DONE.
- load_done  output  1  level; image loaded and processor released.
- load_error  output  1  level; load aborted.

## Operation
- Byte transfer occurs on an edge where byte_valid && byte_ready. byte_valid may drop at any time; no byte is lost or duplicated.
- Stream format: LEN_LO, LEN_HI (16-bit word count N, little-endian), then 4·N data bytes (per word, LSB first), then the checksum byte (only with the macro).
- States: IDLE → (start) LEN_LO → LEN_HI → DATA → CHECK → DONE; ERROR reachable from LEN_HI and CHECK.
- byte_ready is high in LEN_LO, LEN_HI, DATA, CHECK; low elsewhere and during the write-pulse cycle.
- LEN_HI accept: N == 0 or N > MEMORY_DEPTH → ERROR, no writes.
- DATA: 2-bit lane counter and word index. The 4th byte of word i triggers mem_write_enable, with address BASE_ADDRESS + 4·i and data {b3,b2,b1,b0}. Both are valid only in the pulse cycle and are otherwise held at their last value.
- After the final word write the loader goes to CHECK (macro on) or DONE (macro off).
- DONE: cpu_reset=0, load_done=1. ERROR: cpu_reset=1, load_error=1. Both hold until start or reset.
- start in DONE or ERROR: clear flags, reassert cpu_reset, enter LEN_LO. start in any other state is ignored.
- Reset mid-load: IDLE immediately; no further writes. Words already written stay in memory.

## Timing
- Reset values: byte_ready=0, mem_write_enable=0, mem_write_address=0, mem_write_data=0, cpu_reset=1, load_done=0, load_error=0. State is IDLE.
- start at edge k → byte_ready=1 from cycle k+1.
- 4th byte of a word accepted at edge k → mem_write_enable high for the cycle after edge k. byte_ready is low that cycle, giving a maximum rate of 4 bytes per 5 cycles.
- Macro off: load_done=1 and cpu_reset=0 on the edge ending the final write pulse. The processor never fetches while the last write is in flight.
- Checksum accept at edge k → load_done or load_error asserted from cycle k+1.
- N > MEMORY_DEPTH → load_error asserted the cycle after LEN_HI is accepted.

## Configuration
- LOADER_CHECKSUM_EN defined:
  - CHECK state is present.
  - One trailing byte must equal the XOR of all 4·N data bytes (length bytes excluded).
  - Mismatch → ERROR.
- LOADER_CHECKSUM_EN undefined:
  - No CHECK state, no trailing byte.
  - DONE follows the final write.

## Structure
- Package mips_loader_pkg:
  - State encoding constants.
  - LEN_WIDTH=16.
  - BYTES_PER_WORD=4.
  - The word-index width function clog2(MEMORY_DEPTH+1).
- Sub-module word_assembler:
  - Lane counter and 32-bit shift/lane register.
  - Emits word_valid and the word on the 4th byte.
  - Clear input driven by the FSM on start and reset.

## Test plan
- N=2, bytes 02 00 05 00 08 20 07 00 09 20 [03] → writes (0x0,0x20080005), (0x4,0x20090007), then load_done=1, cpu_reset=0.
- Bytes 21 00 with MEMORY_DEPTH=32 → load_error=1 the cycle after the 2nd byte, no mem_write_enable, cpu_reset=1. Bytes 00 00 give the same result.
- Macro on, test 1 stream with checksum 04 → both writes occur, then load_error=1 and cpu_reset stays 1.
- Test 1 stream with byte_valid toggled every other cycle → identical writes and result; no byte accepted while byte_ready=0.
- reset after the 3rd data byte → all outputs at reset values next cycle, no write. A fresh start plus the test 1 stream loads correctly.
- start pulsed during DATA → ignored. start in DONE → cpu_reset=1 and load_done=0 next cycle, LEN_LO entered.
